sample_burst_writer: RTL
========================

# sample_burst_writer

Downstream of the capture front end and alongside the sample-to-address conversion, this block packs 32-bit sample packets into 128-bit memory-controller write bursts and issues them to the DDR user interface. Each burst holds four consecutive samples at a burst-aligned address: first sample number × 2 words, low 3 bits zero. Sample numbering, ring-buffer wrap and partial-burst flush are handled here, so the capture logic sees only a valid/ready stream.

## Interface
- SAMPLE_PACKET_WIDTH, 32, bits per sample packet (fixed at 32 in this block)
- ADX_WIDTH, 27, memory address width
- MEMORY_WORD_WIDTH, 2, bytes per memory word
- MAX_SAMPLES, 32'h0100_0000, ring capacity in samples; must be a multiple of 4

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  allow acceptance of new samples
- flush  in  1  single-cycle pulse; write any partial burst
- sample_valid  in  1  sample present
- sample_data  in  32  sample packet
- sample_ready  out  1  sample accepted when valid && ready
- app_rdy  in  1  controller command ready
- app_en  out  1  command valid
- app_cmd  out  3  always 3'b000 (write)
- app_addr  out  ADX_WIDTH  burst address
- app_wdf_rdy  in  1  write-data ready
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  equal to app_wdf_wren (single-beat burst)
- app_wdf_data  out  128  four packed samples
- app_wdf_mask  out  16  byte mask; 1 = byte not written
- sample_count  out  32  number of the next sample to be assigned
- wrapped  out  1  sticky; ring has wrapped at least once
- busy  out  1  burst in flight or partial burst held

## Operation
- FSM states: COLLECT, ISSUE.
- COLLECT: sample_ready = enable. Each accepted sample goes into lane fill_cnt (0..3), at bits [32k+31:32k]. fill_cnt and sample_count then increment.
- Burst base sample is latched when lane 0 fills. app_addr = {(base*2)[ADX_WIDTH-1:3], 3'b000}.
- Lane 3 accepted -> ISSUE with mask 16'h0000.
- flush with fill_cnt>0 -> ISSUE. Mask bits 4k..4k+3 are set for every unfilled lane k. sample_count then rounds up to the next multiple of 4.
- flush with fill_cnt==0 is a no-op.
- Sample accepted in the same cycle as flush: the sample joins the burst first, then the flush applies.
- ISSUE: app_en and app_wdf_wren both assert. Each deasserts independently after its own handshake (app_en&&app_rdy; app_wdf_wren&&app_wdf_rdy). When both handshakes are done -> COLLECT, fill_cnt=0, data and mask cleared.
- app_addr, app_wdf_data and app_wdf_mask are stable throughout ISSUE. sample_ready=0 in ISSUE.
- enable low blocks new samples only. A held partial burst or an in-flight ISSUE completes normally.
- busy = (state==ISSUE) || fill_cnt!=0.

## Timing
- Reset values: all outputs 0. State COLLECT, fill_cnt 0.
- Fourth sample accepted at edge N:
  - app_en, app_wdf_wren and app_wdf_end are 1 during cycle N+1.
  - If app_rdy and app_wdf_rdy are both 1 at edge N+1, state is COLLECT and sample_ready=enable in cycle N+2.
- Both handshakes can complete in one cycle, or in different cycles in either order. No command or data beat is ever repeated.
- rst at any edge, including mid-ISSUE, aborts immediately. The partial burst is discarded; sample_count=0 and wrapped=0 on the following cycle.
- Width rule: base*2 is computed in 32 bits and truncated to ADX_WIDTH.

## Configuration
- SAMPLE_WRAP_EN defined:
  - When sample_count reaches MAX_SAMPLES, including via flush round-up, it becomes 0 and wrapped sets.
  - Capture continues overwriting from address 0.
- Undefined:
  - On reaching MAX_SAMPLES, sample_ready holds 0 and further flushes are ignored until rst.
  - wrapped stays 0.

## Test plan
- Four samples 32'h11111111..32'h44444444, both rdy high:
  - one write, app_addr=0, app_wdf_data=128'h44444444_33333333_22222222_11111111, mask 16'h0000.
  - Next four samples -> app_addr=8.
- app_rdy low for 5 cycles, app_wdf_rdy high:
  - app_wdf_wren high exactly 1 cycle; app_en high 6 cycles.
  - exactly one command and one data beat; address and data stable throughout.
- Two samples then flush:
  - mask 16'hFF00, app_addr=0, sample_count=4.
  - next burst at app_addr=8.
- Flush with no samples held -> no app_en, no app_wdf_wren; sample_count unchanged.
- MAX_SAMPLES=8, 12 samples:
  - with SAMPLE_WRAP_EN: third burst at app_addr=0, wrapped=1.
  - without SAMPLE_WRAP_EN: only two bursts, sample_ready=0 after sample 8.
- rst asserted in ISSUE with app_rdy low -> next cycle: app_en=0, app_wdf_wren=0, sample_count=0; following burst at app_addr=0.

Source files
------------

// File: rtl/sample_burst_writer.sv
// sample_burst_writer: packs four 32-bit samples into one 128-bit DDR write burst with ring numbering and flush.
// Define SAMPLE_WRAP_EN to wrap numbering at MAX_SAMPLES; otherwise capture stalls there until rst.
module sample_burst_writer #(
  parameter int          SAMPLE_PACKET_WIDTH = 32,
  parameter int          ADX_WIDTH           = 27,
  parameter int          MEMORY_WORD_WIDTH   = 2,
  parameter logic [31:0] MAX_SAMPLES         = 32'h0100_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           flush,
  input  logic                           sample_valid,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] sample_data,
  output logic                           sample_ready,
  input  logic                           app_rdy,
  output logic                           app_en,
  output logic [2:0]                     app_cmd,
  output logic [ADX_WIDTH-1:0]           app_addr,
  input  logic                           app_wdf_rdy,
  output logic                           app_wdf_wren,
  output logic                           app_wdf_end,
  output logic [127:0]                   app_wdf_data,
  output logic [15:0]                    app_wdf_mask,
  output logic [31:0]                    sample_count,
  output logic                           wrapped,
  output logic                           busy
);
  localparam logic [31:0] WORDS_PER_SAMPLE = 32'(SAMPLE_PACKET_WIDTH / (8 * MEMORY_WORD_WIDTH));
  typedef enum logic {COLLECT, ISSUE} state_t;
  state_t r_state, w_state_n;
  logic [1:0] r_fill;
  logic [2:0] w_fill_n;
  logic [31:0] r_count, r_base, w_count_inc, w_count_rnd, w_count_n;
  logic [ADX_WIDTH-1:0] w_adx;
  logic [127:0] r_data;
  logic [15:0] r_mask, w_mask_n;
  logic r_wrapped, r_cmd_done, r_dat_done;
  logic w_stop, w_wrap, w_accept, w_last, w_flush, w_done;
`ifdef SAMPLE_WRAP_EN
  assign w_stop = 1'b0;
  assign w_wrap = w_count_rnd == MAX_SAMPLES;
`else
  assign w_stop = r_count == MAX_SAMPLES;
  assign w_wrap = 1'b0;
`endif
  assign sample_ready = r_state == COLLECT && enable && !w_stop;
  assign w_accept     = sample_valid && sample_ready;
  assign w_fill_n     = {1'b0, r_fill} + {2'b0, w_accept};
  assign w_last       = w_accept && r_fill == 2'd3;
  // a sample arriving with flush joins the burst before the flush is judged
  assign w_flush      = flush && r_state == COLLECT && !w_stop && !w_last && w_fill_n != 3'd0;
  assign w_done       = r_state == ISSUE && (r_cmd_done || app_rdy) && (r_dat_done || app_wdf_rdy);
  assign w_count_inc  = r_count + {31'b0, w_accept};
  assign w_count_rnd  = w_flush ? (w_count_inc + 32'd3) & ~32'd3 : w_count_inc;
  assign w_count_n    = w_wrap ? '0 : w_count_rnd;
  assign w_adx        = ADX_WIDTH'(r_base * WORDS_PER_SAMPLE);
  assign app_addr     = w_adx & ~ADX_WIDTH'(7);
  assign app_en       = r_state == ISSUE && !r_cmd_done;
  assign app_wdf_wren = r_state == ISSUE && !r_dat_done;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = 3'b000;
  assign app_wdf_data = r_data;
  assign app_wdf_mask = r_mask;
  assign sample_count = r_count;
  assign wrapped      = r_wrapped;
  assign busy         = r_state == ISSUE || r_fill != 2'd0;
  always_comb begin
    w_mask_n = '0;
    for (int k = 0; k < 4; k++) w_mask_n[4*k +: 4] = {4{3'(k) >= w_fill_n}};
  end
  always_comb begin
    w_state_n = r_state;
    w_state_n = r_state == COLLECT ? ((w_last || w_flush) ? ISSUE : COLLECT) : (w_done ? COLLECT : ISSUE);
  end
  always_ff @(posedge clk) r_state <= rst ? COLLECT : w_state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill     <= '0;
      r_count    <= '0;
      r_base     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_wrapped  <= 1'b0;
      r_cmd_done <= 1'b0;
      r_dat_done <= 1'b0;
    end else begin
      r_count <= w_count_n;
      if (w_wrap) r_wrapped <= 1'b1;
      if (w_accept) begin
        r_data[SAMPLE_PACKET_WIDTH*r_fill +: SAMPLE_PACKET_WIDTH] <= sample_data;
        r_fill <= r_fill + 2'd1;
        if (r_fill == 2'd0) r_base <= r_count;
      end
      if (w_flush) r_mask <= w_mask_n;
      if (app_en && app_rdy) r_cmd_done <= 1'b1;
      if (app_wdf_wren && app_wdf_rdy) r_dat_done <= 1'b1;
      if (w_done) begin
        r_fill     <= '0;
        r_data     <= '0;
        r_mask     <= '0;
        r_cmd_done <= 1'b0;
        r_dat_done <= 1'b0;
      end
    end
  end
endmodule
